// File: rtl/phj_input_pkg.sv
// Shared types, constants and helpers for the hash-join input framer.
package phj_input_pkg;

    localparam int unsigned NUM_LANES = 8;
    localparam int unsigned LANE_BITS = $clog2(NUM_LANES);
    localparam int unsigned CNT_W     = 32;

    typedef enum logic [1:0] {
        StIdle,
        StBuild,
        StProbe,
        StDrain
    } framer_state_e;

    // Lane mask for the last beat of a relation, from N mod NUM_LANES.
    function automatic logic [NUM_LANES-1:0] tail_mask(input logic [LANE_BITS-1:0] rem);
        logic [NUM_LANES-1:0] m;
        m = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            m[i] = (rem == '0) || (LANE_BITS'(i) < rem);
        end
        return m;
    endfunction

    // Beats needed for N tuples; one extra bit so N = 2^CNT_W-1 cannot wrap.
    function automatic logic [CNT_W:0] beat_count(input logic [CNT_W-1:0] n);
        logic [CNT_W:0] sum;
        sum = {1'b0, n} + (CNT_W+1)'(NUM_LANES - 1);
        return sum >> LANE_BITS;
    endfunction

endpackage

// File: rtl/phj_skid_buffer.sv
// Two-entry skid buffer with a registered ready; output is zero while empty.
module phj_skid_buffer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_q;
    logic             rd_q;
    logic [1:0]       cnt_q;
    logic [1:0]       cnt_d;
    logic             ready_q;
    logic             push;
    logic             pop;

    assign push      = in_valid & ready_q;
    assign pop       = out_valid & out_ready;
    assign out_valid = (cnt_q != 2'd0);
    assign out_data  = out_valid ? mem_q[rd_q] : '0;
    assign in_ready  = ready_q;

    // Occupancy after this cycle's accept and release.
    always_comb begin
        cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    end

    // Storage, pointers and the ready flag that looks one cycle ahead.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            cnt_q    <= 2'd0;
            ready_q  <= 1'b1;
        end else begin
            if (push) begin
                mem_q[wr_q] <= in_data;
                wr_q        <= ~wr_q;
            end
            if (pop) begin
                rd_q <= ~rd_q;
            end
            cnt_q   <= cnt_d;
            ready_q <= (cnt_d < 2'd2);
        end
    end

endmodule

// File: rtl/phj_input_framer.sv
// Frames a raw beat stream into build then probe relations with lane masks and
// last flags. Lane count and counter width come from phj_input_pkg.
module phj_input_framer
    import phj_input_pkg::*;
#(
    parameter int unsigned TUPLE_W = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CNT_W-1:0]             cfg_build_count,
    input  logic [CNT_W-1:0]             cfg_probe_count,
    input  logic                         cfg_start,
    output logic                         cfg_busy,
    output logic                         cfg_done,
    output logic                         cfg_err,
    input  logic [NUM_LANES*TUPLE_W-1:0] s_data,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic                         s_last,
    output logic [NUM_LANES*TUPLE_W-1:0] m_data,
    output logic [NUM_LANES-1:0]         m_valid,
    input  logic                         m_ready,
    output logic                         m_last_build,
    output logic                         m_last_probe,
    output logic                         m_last
);

    localparam int unsigned DATA_W = NUM_LANES * TUPLE_W;
    localparam int unsigned PAY_W  = DATA_W + NUM_LANES + 2;

    framer_state_e        state_q;
    logic [CNT_W:0]       rem_q;
    logic [CNT_W:0]       probe_beats_q;
    logic [NUM_LANES-1:0] build_tail_q;
    logic [NUM_LANES-1:0] probe_tail_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 err_q;

    logic                 accepting;
    logic                 skid_ready;
    logic                 in_fire;
    logic                 final_beat;
    logic [NUM_LANES-1:0] push_mask;
    logic [DATA_W-1:0]    push_data;
    logic                 push_lb;
    logic                 push_lp;
    logic [PAY_W-1:0]     out_pay;
    logic                 out_valid;
    logic                 pop;

    assign accepting  = (state_q == StBuild) || (state_q == StProbe);
    assign s_ready    = accepting & skid_ready;
    assign in_fire    = s_valid & s_ready;
    assign final_beat = (rem_q == (CNT_W+1)'(1));
    assign push_lb    = (state_q == StBuild) && final_beat;
    assign push_lp    = (state_q == StProbe) && final_beat;
    assign pop        = m_ready & out_valid;

    // Lane mask for the incoming beat; disabled lanes are zeroed before buffering.
    always_comb begin
        push_mask = '1;
        push_data = '0;
        if (final_beat) begin
            push_mask = (state_q == StBuild) ? build_tail_q : probe_tail_q;
        end
        for (int i = 0; i < NUM_LANES; i++) begin
            push_data[i*TUPLE_W +: TUPLE_W] = s_data[i*TUPLE_W +: TUPLE_W] & {TUPLE_W{push_mask[i]}};
        end
    end

    phj_skid_buffer #(
        .WIDTH (PAY_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_data   ({push_lp, push_lb, push_mask, push_data}),
        .in_valid  (s_valid & accepting),
        .in_ready  (skid_ready),
        .out_data  (out_pay),
        .out_valid (out_valid),
        .out_ready (m_ready)
    );

    assign m_data       = out_pay[DATA_W-1:0];
    assign m_valid      = out_pay[DATA_W +: NUM_LANES];
    assign m_last_build = out_pay[DATA_W + NUM_LANES];
    assign m_last_probe = out_pay[DATA_W + NUM_LANES + 1];
    assign m_last       = m_last_probe;
    assign cfg_busy     = busy_q;
    assign cfg_done     = done_q;
    assign cfg_err      = err_q;

    // Run FSM, remaining-beat counter and sticky length checker.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            rem_q         <= '0;
            probe_beats_q <= '0;
            build_tail_q  <= '0;
            probe_tail_q  <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (cfg_start) begin
                        if ((cfg_build_count != '0) && (cfg_probe_count != '0)) begin
                            rem_q         <= beat_count(cfg_build_count);
                            probe_beats_q <= beat_count(cfg_probe_count);
                            build_tail_q  <= tail_mask(cfg_build_count[LANE_BITS-1:0]);
                            probe_tail_q  <= tail_mask(cfg_probe_count[LANE_BITS-1:0]);
                            err_q         <= 1'b0;
                            busy_q        <= 1'b1;
                            state_q       <= StBuild;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                StBuild: begin
                    if (in_fire) begin
                        if (final_beat) begin
                            rem_q   <= probe_beats_q;
                            state_q <= StProbe;
                        end else begin
                            rem_q <= rem_q - 1'b1;
                        end
                    end
                end
                StProbe: begin
                    if (in_fire) begin
                        rem_q <= rem_q - 1'b1;
                        if (final_beat) begin
                            state_q <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    // The final probe beat is always the last one in the buffer.
                    if (pop && m_last_probe) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
            if (in_fire && (s_last != push_lp)) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_phj_input_framer.sv
// Self-checking bench for phj_input_framer: table-driven runs, randomized runs
// against a tuple-count model, and hand-written reset/overflow sequences.
module tb_phj_input_framer;
    import phj_input_pkg::*;

    localparam int unsigned TW = 64;
    localparam int unsigned DW = NUM_LANES * TW;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [CNT_W-1:0]     cfg_build_count;
    logic [CNT_W-1:0]     cfg_probe_count;
    logic                 cfg_start;
    logic                 cfg_busy;
    logic                 cfg_done;
    logic                 cfg_err;
    logic [DW-1:0]        s_data;
    logic                 s_valid;
    logic                 s_ready;
    logic                 s_last;
    logic [DW-1:0]        m_data;
    logic [NUM_LANES-1:0] m_valid;
    logic                 m_ready;
    logic                 m_last_build;
    logic                 m_last_probe;
    logic                 m_last;

    phj_input_framer #(
        .TUPLE_W (TW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .cfg_build_count (cfg_build_count),
        .cfg_probe_count (cfg_probe_count),
        .cfg_start       (cfg_start),
        .cfg_busy        (cfg_busy),
        .cfg_done        (cfg_done),
        .cfg_err         (cfg_err),
        .s_data          (s_data),
        .s_valid         (s_valid),
        .s_ready         (s_ready),
        .s_last          (s_last),
        .m_data          (m_data),
        .m_valid         (m_valid),
        .m_ready         (m_ready),
        .m_last_build    (m_last_build),
        .m_last_probe    (m_last_probe),
        .m_last          (m_last)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [DW-1:0]        data;
        logic [NUM_LANES-1:0] mask;
        logic                 lb;
        logic                 lp;
    } beat_t;

    typedef struct {
        logic [31:0] b;
        logic [31:0] p;
        int          last_idx;
        int          rmode;
        int          vmode;
        logic        exp_err;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic chk_wide(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic logic [DW-1:0] rand_beat();
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, ".s_ready"}, 64'(s_ready), 64'd0);
        chk({tag, ".m_valid"}, 64'(m_valid), 64'd0);
        chk({tag, ".m_data_any"}, 64'(|m_data), 64'd0);
        chk({tag, ".flags"}, 64'({m_last_build, m_last_probe, m_last}), 64'd0);
        chk({tag, ".cfg"}, 64'({cfg_busy, cfg_done, cfg_err}), 64'd0);
    endtask

    // One complete run; expected beats come from tuple counts alone.
    task automatic run_case(input logic [31:0] b, input logic [31:0] p, input int last_idx,
                            input int rmode, input int vmode, input logic exp_err,
                            input bit use_exp, input string tag);
        longint nb, np, total, rel_n, beats, idx, lanes;
        int     n_in, n_out;
        bit     done_seen, done_next, pend, fire_in, fire_out, model_err;
        beat_t  exp_q[$];
        beat_t  e, snap;
        nb = (longint'(b) + NUM_LANES - 1) / NUM_LANES;
        np = (longint'(p) + NUM_LANES - 1) / NUM_LANES;
        total = nb + np;
        n_in = 0; n_out = 0; done_seen = 0; done_next = 0; pend = 0; model_err = 0;
        snap = '{default: '0};
        cfg_build_count = b; cfg_probe_count = p; cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        chk({tag, ".start_busy"}, 64'(cfg_busy), 64'd1);
        chk({tag, ".start_err_clr"}, 64'(cfg_err), 64'd0);
        for (int cyc = 0; cyc < 400 && !done_seen; cyc++) begin
            chk({tag, ".done"}, 64'(cfg_done), 64'(done_next));
            if (done_next) done_seen = 1;
            chk({tag, ".busy"}, 64'(cfg_busy), 64'(!done_seen));
            chk({tag, ".s_ready"}, 64'(s_ready), 64'((n_in < total) && (n_in - n_out < 2)));
            chk({tag, ".out_pending"}, 64'(|m_valid), 64'(n_in - n_out > 0));
            if (pend) begin
                chk({tag, ".hold_flags"}, 64'({m_valid, m_last_build, m_last_probe}),
                    64'({snap.mask, snap.lb, snap.lp}));
                chk_wide({tag, ".hold_data"}, m_data, snap.data);
            end
            case (rmode)
                0:       m_ready = 1'b1;
                1:       m_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: m_ready = ($urandom_range(0, 3) != 0);
            endcase
            s_valid = (n_in < total) ? ((vmode != 0) ? 1'($urandom_range(0, 1)) : 1'b1) : 1'b0;
            s_data  = rand_beat();
            s_last  = (n_in == last_idx);
            fire_out  = m_ready && (|m_valid);
            fire_in   = s_valid && s_ready;
            done_next = 0;
            if (fire_out) begin
                if (exp_q.size() == 0) begin
                    chk({tag, ".unexpected_beat"}, 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk({tag, ".beat_flags"}, 64'({m_valid, m_last_build, m_last_probe, m_last}),
                        64'({e.mask, e.lb, e.lp, e.lp}));
                    chk_wide({tag, ".beat_data"}, m_data, e.data);
                    done_next = e.lp;
                end
                n_out++;
            end
            if (fire_in) begin
                if (n_in < nb) begin rel_n = longint'(b); beats = nb; idx = n_in; end
                else begin rel_n = longint'(p); beats = np; idx = n_in - nb; end
                lanes  = (idx == beats - 1) ? rel_n - NUM_LANES * (beats - 1) : NUM_LANES;
                e.mask = NUM_LANES'((16'd1 << lanes) - 16'd1);
                e.lb   = (n_in < nb) && (idx == beats - 1);
                e.lp   = (n_in >= nb) && (idx == beats - 1);
                for (int l = 0; l < NUM_LANES; l++)
                    e.data[l*TW +: TW] = e.mask[l] ? s_data[l*TW +: TW] : '0;
                exp_q.push_back(e);
                if (s_last != (longint'(n_in) == total - 1)) model_err = 1;
                n_in++;
            end
            pend = (|m_valid) && !fire_out;
            snap.data = m_data; snap.mask = m_valid; snap.lb = m_last_build; snap.lp = m_last_probe;
            step();
        end
        s_valid = 1'b0; s_last = 1'b0;
        if (!done_seen) chk({tag, ".timeout"}, 64'd1, 64'd0);
        chk({tag, ".beats_out"}, 64'(n_out), 64'(total));
        chk({tag, ".done_pulse_end"}, 64'(cfg_done), 64'd0);
        chk({tag, ".err"}, 64'(cfg_err), 64'(use_exp ? exp_err : model_err));
        chk({tag, ".ready_after"}, 64'(s_ready), 64'd0);
    endtask

    vec_t          vecs[6];
    logic [DW-1:0] d;
    int            tot;
    logic [31:0]   rb, rp;

    initial begin
        rst = 1'b1; cfg_start = 1'b0; cfg_build_count = '0; cfg_probe_count = '0;
        s_data = '0; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b0;
        step(); step();
        check_idle("reset");
        rst = 1'b0;
        step();

        vecs[0] = '{b: 16, p: 8,  last_idx: 2, rmode: 0, vmode: 0, exp_err: 1'b0};
        vecs[1] = '{b: 13, p: 3,  last_idx: 2, rmode: 0, vmode: 0, exp_err: 1'b0};
        vecs[2] = '{b: 16, p: 8,  last_idx: 2, rmode: 1, vmode: 0, exp_err: 1'b0};
        vecs[3] = '{b: 5,  p: 9,  last_idx: 1, rmode: 0, vmode: 0, exp_err: 1'b1};
        vecs[4] = '{b: 8,  p: 8,  last_idx: 1, rmode: 2, vmode: 1, exp_err: 1'b0};
        vecs[5] = '{b: 7,  p: 17, last_idx: 9, rmode: 1, vmode: 1, exp_err: 1'b1};
        for (int i = 0; i < 6; i++) begin
            run_case(vecs[i].b, vecs[i].p, vecs[i].last_idx, vecs[i].rmode, vecs[i].vmode,
                     vecs[i].exp_err, 1'b1, $sformatf("vec%0d", i));
        end

        // Zero counts are rejected and leave the block idle.
        cfg_build_count = 0; cfg_probe_count = 5; cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        chk("zero_build.err", 64'(cfg_err), 64'd1);
        chk("zero_build.busy", 64'(cfg_busy), 64'd0);
        step();
        chk("zero_build.busy_stays", 64'({cfg_busy, s_ready}), 64'd0);
        cfg_build_count = 4; cfg_probe_count = 0; cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        chk("zero_probe.err_busy", 64'({cfg_err, cfg_busy}), 64'b10);

        // Reset mid-run with one beat output and one still buffered; start ignored.
        cfg_build_count = 16; cfg_probe_count = 16; cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        s_valid = 1'b1; s_last = 1'b0; s_data = rand_beat(); m_ready = 1'b0;
        step();
        s_data = rand_beat(); m_ready = 1'b1;
        step();
        chk("midrst.buffered", 64'(m_valid), 64'hFF);
        rst = 1'b1; cfg_start = 1'b1; s_valid = 1'b0;
        step();
        rst = 1'b0; cfg_start = 1'b0;
        check_idle("midrst");
        step();
        chk("midrst.start_ignored", 64'(cfg_busy), 64'd0);
        run_case(8, 8, 1, 0, 0, 1'b0, 1'b1, "after_rst");

        // Randomized runs checked against the count model.
        for (int i = 0; i < 6; i++) begin
            rb  = $urandom_range(1, 40);
            rp  = $urandom_range(1, 40);
            tot = int'((rb + 7) / 8 + (rp + 7) / 8);
            run_case(rb, rp, ($urandom_range(0, 3) == 0) ? $urandom_range(0, tot) : tot - 1,
                     $urandom_range(0, 2), $urandom_range(0, 1), 1'b0, 1'b0,
                     $sformatf("rnd%0d", i));
        end

        // Largest build count: beat count must not wrap.
        chk("pkg.beat_count_max", 64'(beat_count(32'hFFFF_FFFF)), 64'h2000_0000);
        chk("pkg.tail_mask_7", 64'(tail_mask(3'd7)), 64'h7F);
        cfg_build_count = 32'hFFFF_FFFF; cfg_probe_count = 1; cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        chk("big.rem", 64'(dut.rem_q), 64'h2000_0000);
        d = rand_beat();
        s_data = d; s_valid = 1'b1; s_last = 1'b0; m_ready = 1'b0;
        step();
        s_valid = 1'b0;
        chk("big.first_flags", 64'({m_valid, m_last_build, m_last_probe}), 64'({8'hFF, 2'b00}));
        chk_wide("big.first_data", m_data, d);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle("big_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
